// File: rtl/dijkstra_pkg.sv
// Shared types and constants for the dijkstra datapath blocks.
package dijkstra_pkg;

  localparam int unsigned DEFAULT_MADDR_WIDTH = 16;
  localparam int unsigned DEFAULT_MDATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_RD_BUSY = 2'd1,
    ARB_WR_BUSY = 2'd2
  } arb_state_t;

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

  // Round-robin tie break: the read side wins unless it was granted last.
  function automatic logic pick_read(input logic rd_req, input logic wr_req,
                                     input logic last_grant);
    return rd_req && (!wr_req || (last_grant == GRANT_WR));
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating busy-cycle counter that flags the last allowed cycle of a memory transaction.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT =
    TIMEOUT_ON ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  logic [TIMEOUT_WIDTH-1:0] r_count;

  // Stops at the expiry value instead of wrapping; held at zero when disabled.
  always_ff @(posedge clock) begin
    if (reset || i_clear || !TIMEOUT_ON) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST_COUNT)) begin
      r_count <= r_count + TIMEOUT_WIDTH'(1);
    end
  end

  assign o_expired_c = TIMEOUT_ON && i_enable && (r_count == LAST_COUNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the external memory port between the edge-cache reader and the result writer,
// one registered transaction at a time, with a response timeout and sticky error flag.
module mem_port_arbiter
  import dijkstra_pkg::*;
#(
  parameter int unsigned MADDR_WIDTH    = DEFAULT_MADDR_WIDTH,
  parameter int unsigned MDATA_WIDTH    = DEFAULT_MDATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_req,
  input  logic [MADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_ack,
  output logic [MDATA_WIDTH-1:0] rd_data,
  input  logic                   wr_req,
  input  logic [MADDR_WIDTH-1:0] wr_addr,
  input  logic [MDATA_WIDTH-1:0] wr_data,
  output logic                   wr_ack,
  output logic                   xfer_err,
  output logic                   timeout_error,
  output logic                   mem_read_enable,
  output logic                   mem_write_enable,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  output logic [MDATA_WIDTH-1:0] mem_write_data,
  input  logic [MDATA_WIDTH-1:0] mem_read_data,
  input  logic                   mem_read_ready,
  input  logic                   mem_write_ready
);

  arb_state_t             r_state;
  logic                   r_last_grant;
  logic                   r_rd_en;
  logic                   r_wr_en;
  logic [MADDR_WIDTH-1:0] r_addr;
  logic [MDATA_WIDTH-1:0] r_wdata;
  logic [MDATA_WIDTH-1:0] r_rd_data;
  logic                   r_rd_ack;
  logic                   r_wr_ack;
  logic                   r_xfer_err;
  logic                   r_timeout_error;

  arb_state_t             w_state_nxt;
  logic                   w_last_grant_nxt;
  logic                   w_rd_en_nxt;
  logic                   w_wr_en_nxt;
  logic [MADDR_WIDTH-1:0] w_addr_nxt;
  logic [MDATA_WIDTH-1:0] w_wdata_nxt;
  logic [MDATA_WIDTH-1:0] w_rd_data_nxt;
  logic                   w_rd_ack_nxt;
  logic                   w_wr_ack_nxt;
  logic                   w_xfer_err_nxt;
  logic                   w_timeout_error_nxt;
  logic                   w_expired;

  mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (r_state == ARB_IDLE),
    .i_enable   (r_state != ARB_IDLE),
    .o_expired_c(w_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ARB_IDLE;
      r_last_grant    <= GRANT_WR;
      r_rd_en         <= 1'b0;
      r_wr_en         <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_rd_data       <= '0;
      r_rd_ack        <= 1'b0;
      r_wr_ack        <= 1'b0;
      r_xfer_err      <= 1'b0;
      r_timeout_error <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_last_grant    <= w_last_grant_nxt;
      r_rd_en         <= w_rd_en_nxt;
      r_wr_en         <= w_wr_en_nxt;
      r_addr          <= w_addr_nxt;
      r_wdata         <= w_wdata_nxt;
      r_rd_data       <= w_rd_data_nxt;
      r_rd_ack        <= w_rd_ack_nxt;
      r_wr_ack        <= w_wr_ack_nxt;
      r_xfer_err      <= w_xfer_err_nxt;
      r_timeout_error <= w_timeout_error_nxt;
    end
  end

  // Requests seen during an ack cycle belong to the finishing requester and are ignored.
  always_comb begin
    w_state_nxt         = r_state;
    w_last_grant_nxt    = r_last_grant;
    w_rd_en_nxt         = r_rd_en;
    w_wr_en_nxt         = r_wr_en;
    w_addr_nxt          = r_addr;
    w_wdata_nxt         = r_wdata;
    w_rd_data_nxt       = r_rd_data;
    w_rd_ack_nxt        = 1'b0;
    w_wr_ack_nxt        = 1'b0;
    w_xfer_err_nxt      = 1'b0;
    w_timeout_error_nxt = r_timeout_error;
    case (r_state)
      ARB_IDLE: begin
        if (!r_rd_ack && !r_wr_ack) begin
          if (pick_read(rd_req, wr_req, r_last_grant)) begin
            w_state_nxt = ARB_RD_BUSY;
            w_rd_en_nxt = 1'b1;
            w_addr_nxt  = rd_addr;
          end else if (wr_req) begin
            w_state_nxt = ARB_WR_BUSY;
            w_wr_en_nxt = 1'b1;
            w_addr_nxt  = wr_addr;
            w_wdata_nxt = wr_data;
          end
        end
      end
      ARB_RD_BUSY: begin
        if (mem_read_ready || w_expired) begin
          w_state_nxt      = ARB_IDLE;
          w_rd_en_nxt      = 1'b0;
          w_rd_ack_nxt     = 1'b1;
          w_last_grant_nxt = GRANT_RD;
          if (mem_read_ready) begin
            w_rd_data_nxt = mem_read_data;
          end else begin
            w_xfer_err_nxt      = 1'b1;
            w_timeout_error_nxt = 1'b1;
          end
        end
      end
      ARB_WR_BUSY: begin
        if (mem_write_ready || w_expired) begin
          w_state_nxt      = ARB_IDLE;
          w_wr_en_nxt      = 1'b0;
          w_wr_ack_nxt     = 1'b1;
          w_last_grant_nxt = GRANT_WR;
          if (!mem_write_ready) begin
            w_xfer_err_nxt      = 1'b1;
            w_timeout_error_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_rd_en_nxt = 1'b0;
        w_wr_en_nxt = 1'b0;
      end
    endcase
  end

  assign rd_ack           = r_rd_ack;
  assign rd_data          = r_rd_data;
  assign wr_ack           = r_wr_ack;
  assign xfer_err         = r_xfer_err;
  assign timeout_error    = r_timeout_error;
  assign mem_read_enable  = r_rd_en;
  assign mem_write_enable = r_wr_en;
  assign mem_addr         = r_addr;
  assign mem_write_data   = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter: cycle tables plus timeout/expiry sequences.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        xfer_err;
  logic        timeout_error;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [15:0] mem_addr;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        mem_read_ready;
  logic        mem_write_ready;

  int n_checks   = 0;
  int n_failures = 0;
  bit mon_on     = 1'b0;

  mem_port_arbiter #(
    .MADDR_WIDTH(16), .MDATA_WIDTH(16), .TIMEOUT_CYCLES(8), .TIMEOUT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .xfer_err(xfer_err), .timeout_error(timeout_error),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_read_ready(mem_read_ready),
    .mem_write_ready(mem_write_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        rr;
    logic [15:0] ra;
    logic        wr;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        rrdy;
    logic        wrdy;
    logic [15:0] rdat;
    logic        e_ren;
    logic        e_wen;
    logic [15:0] e_addr;
    logic [15:0] e_wd;
    logic        e_rack;
    logic        e_wack;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic rr, input logic [15:0] ra,
                              input logic wr, input logic [15:0] wa, input logic [15:0] wd,
                              input logic rrdy, input logic wrdy, input logic [15:0] rdat,
                              input logic ern, input logic ewn, input logic [15:0] ea,
                              input logic [15:0] ewd, input logic erk, input logic ewk,
                              input logic [15:0] erd);
    vec_t v;
    v.rst = rst; v.rr = rr; v.ra = ra; v.wr = wr; v.wa = wa; v.wd = wd;
    v.rrdy = rrdy; v.wrdy = wrdy; v.rdat = rdat;
    v.e_ren = ern; v.e_wen = ewn; v.e_addr = ea; v.e_wd = ewd;
    v.e_rack = erk; v.e_wack = ewk; v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s [%0d]: got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    reset = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    mem_read_data = '0; mem_read_ready = 1'b0; mem_write_ready = 1'b0;
  endtask

  // Enables and acks are mutually exclusive in every cycle.
  always @(negedge clock) begin
    if (mon_on) begin
      n_checks++;
      if ((mem_read_enable && mem_write_enable) || (rd_ack && wr_ack)) begin
        n_failures++;
        $display("FAIL exclusive: ren=%b wen=%b rack=%b wack=%b expected no overlap",
                 mem_read_enable, mem_write_enable, rd_ack, wr_ack);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    reset = 1'b1;
    //             rst rr ra      wr wa      wd       rrdy wrdy rdat     | ren wen addr     wd       rack wack rdata
    vecs.push_back(mk(1, 0, 16'h00, 0, 16'h00, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h00, 16'h0000, 0, 0, 16'h0000));
    // single read, ready three cycles after enable
    vecs.push_back(mk(0, 1, 16'h40, 0, 16'h00, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h40, 16'h0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h40, 0, 16'h00, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h40, 16'h0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h40, 0, 16'h00, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h40, 16'h0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h40, 0, 16'h00, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h40, 16'h0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h40, 0, 16'h00, 16'h0000, 1, 0, 16'hBEEF, 0, 0, 16'h40, 16'h0000, 1, 0, 16'hBEEF));
    vecs.push_back(mk(0, 0, 16'h00, 0, 16'h00, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h40, 16'h0000, 0, 0, 16'hBEEF));
    // tie after reset: read first; second tie (last grant read) goes to write
    vecs.push_back(mk(1, 0, 16'h00, 0, 16'h00, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h00, 16'h0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h10, 1, 16'h20, 16'h1234, 0, 0, 16'h0000, 1, 0, 16'h10, 16'h0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h10, 1, 16'h20, 16'h1234, 0, 0, 16'h0000, 1, 0, 16'h10, 16'h0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h10, 1, 16'h20, 16'h1234, 1, 0, 16'h5555, 0, 0, 16'h10, 16'h0000, 1, 0, 16'h5555));
    vecs.push_back(mk(0, 0, 16'h00, 1, 16'h20, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h10, 16'h0000, 0, 0, 16'h5555));
    vecs.push_back(mk(0, 1, 16'h30, 1, 16'h20, 16'h1234, 0, 0, 16'h0000, 0, 1, 16'h20, 16'h1234, 0, 0, 16'h5555));
    vecs.push_back(mk(0, 1, 16'h30, 1, 16'h20, 16'h1234, 1, 0, 16'hDEAD, 0, 1, 16'h20, 16'h1234, 0, 0, 16'h5555));
    vecs.push_back(mk(0, 1, 16'h30, 1, 16'h20, 16'h1234, 0, 1, 16'h0000, 0, 0, 16'h20, 16'h1234, 0, 1, 16'h5555));
    vecs.push_back(mk(0, 1, 16'h30, 0, 16'h00, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h20, 16'h1234, 0, 0, 16'h5555));
    vecs.push_back(mk(0, 1, 16'h30, 0, 16'h00, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h30, 16'h1234, 0, 0, 16'h5555));
    vecs.push_back(mk(0, 1, 16'h30, 0, 16'h00, 16'h0000, 1, 0, 16'hA5A5, 0, 0, 16'h30, 16'h1234, 1, 0, 16'hA5A5));
    vecs.push_back(mk(0, 0, 16'h00, 0, 16'h00, 16'h0000, 0, 1, 16'h0000, 0, 0, 16'h30, 16'h1234, 0, 0, 16'hA5A5));
    // write arrives while a read is busy
    vecs.push_back(mk(0, 1, 16'h44, 0, 16'h00, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h44, 16'h1234, 0, 0, 16'hA5A5));
    vecs.push_back(mk(0, 1, 16'h44, 1, 16'h88, 16'hCAFE, 0, 0, 16'h0000, 1, 0, 16'h44, 16'h1234, 0, 0, 16'hA5A5));
    vecs.push_back(mk(0, 1, 16'h44, 1, 16'h88, 16'hCAFE, 1, 0, 16'h0101, 0, 0, 16'h44, 16'h1234, 1, 0, 16'h0101));
    vecs.push_back(mk(0, 0, 16'h00, 1, 16'h88, 16'hCAFE, 0, 0, 16'h0000, 0, 0, 16'h44, 16'h1234, 0, 0, 16'h0101));
    vecs.push_back(mk(0, 0, 16'h00, 1, 16'h88, 16'hCAFE, 0, 0, 16'h0000, 0, 1, 16'h88, 16'hCAFE, 0, 0, 16'h0101));
    vecs.push_back(mk(0, 0, 16'h00, 1, 16'h88, 16'hCAFE, 0, 1, 16'h0000, 0, 0, 16'h88, 16'hCAFE, 0, 1, 16'h0101));
    vecs.push_back(mk(0, 0, 16'h00, 0, 16'h00, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h88, 16'hCAFE, 0, 0, 16'h0101));
    // reset in the middle of a write, then a normal read
    vecs.push_back(mk(0, 0, 16'h00, 1, 16'h12, 16'h3456, 0, 0, 16'h0000, 0, 1, 16'h12, 16'h3456, 0, 0, 16'h0101));
    vecs.push_back(mk(0, 0, 16'h00, 1, 16'h12, 16'h3456, 0, 0, 16'h0000, 0, 1, 16'h12, 16'h3456, 0, 0, 16'h0101));
    vecs.push_back(mk(1, 0, 16'h00, 1, 16'h12, 16'h3456, 0, 0, 16'h0000, 0, 0, 16'h00, 16'h0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h50, 0, 16'h00, 16'h0000, 0, 1, 16'h0000, 1, 0, 16'h50, 16'h0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h50, 0, 16'h00, 16'h0000, 1, 0, 16'h7777, 0, 0, 16'h50, 16'h0000, 1, 0, 16'h7777));
    vecs.push_back(mk(0, 0, 16'h00, 0, 16'h00, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h50, 16'h0000, 0, 0, 16'h7777));

    foreach (vecs[i]) begin
      reset = vecs[i].rst; rd_req = vecs[i].rr; rd_addr = vecs[i].ra;
      wr_req = vecs[i].wr; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      mem_read_ready = vecs[i].rrdy; mem_write_ready = vecs[i].wrdy;
      mem_read_data = vecs[i].rdat;
      step();
      mon_on = 1'b1;
      chk("mem_read_enable",  i, 32'(mem_read_enable),  32'(vecs[i].e_ren));
      chk("mem_write_enable", i, 32'(mem_write_enable), 32'(vecs[i].e_wen));
      chk("mem_addr",         i, 32'(mem_addr),         32'(vecs[i].e_addr));
      chk("mem_write_data",   i, 32'(mem_write_data),   32'(vecs[i].e_wd));
      chk("rd_ack",           i, 32'(rd_ack),           32'(vecs[i].e_rack));
      chk("wr_ack",           i, 32'(wr_ack),           32'(vecs[i].e_wack));
      chk("rd_data",          i, 32'(rd_data),          32'(vecs[i].e_rdata));
      chk("xfer_err",         i, 32'(xfer_err),         32'd0);
      chk("timeout_error",    i, 32'(timeout_error),    32'd0);
    end

    // Timeout: silent memory, enable high for exactly 8 busy cycles.
    drive_idle();
    wr_req = 1'b1; wr_addr = 16'h77; wr_data = 16'h1111;
    step();
    chk("to_wen_start", 0, 32'(mem_write_enable), 32'd1);
    chk("to_addr", 0, 32'(mem_addr), 32'h77);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("to_wen_busy", k, 32'(mem_write_enable), 32'd1);
      chk("to_wack_busy", k, 32'(wr_ack), 32'd0);
    end
    step();
    chk("to_wen_drop", 0, 32'(mem_write_enable), 32'd0);
    chk("to_wack", 0, 32'(wr_ack), 32'd1);
    chk("to_xfer_err", 0, 32'(xfer_err), 32'd1);
    chk("to_sticky", 0, 32'(timeout_error), 32'd1);
    wr_req = 1'b0;
    step();
    chk("to_wack_pulse", 0, 32'(wr_ack), 32'd0);
    chk("to_xfer_err_pulse", 0, 32'(xfer_err), 32'd0);
    chk("to_sticky_hold", 0, 32'(timeout_error), 32'd1);
    rd_req = 1'b1; rd_addr = 16'h60;
    step();
    chk("good_ren", 0, 32'(mem_read_enable), 32'd1);
    mem_read_ready = 1'b1; mem_read_data = 16'h2222;
    step();
    chk("good_rack", 0, 32'(rd_ack), 32'd1);
    chk("good_xfer_err", 0, 32'(xfer_err), 32'd0);
    chk("good_rdata", 0, 32'(rd_data), 32'h2222);
    chk("good_sticky", 0, 32'(timeout_error), 32'd1);
    rd_req = 1'b0; mem_read_ready = 1'b0;
    step();

    // Ready on the expiry cycle completes normally.
    rd_req = 1'b1; rd_addr = 16'h61;
    step();
    chk("exp_ren_start", 0, 32'(mem_read_enable), 32'd1);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("exp_ren_busy", k, 32'(mem_read_enable), 32'd1);
    end
    mem_read_ready = 1'b1; mem_read_data = 16'h9999;
    step();
    chk("exp_rack", 0, 32'(rd_ack), 32'd1);
    chk("exp_xfer_err", 0, 32'(xfer_err), 32'd0);
    chk("exp_rdata", 0, 32'(rd_data), 32'h9999);
    chk("exp_ren_drop", 0, 32'(mem_read_enable), 32'd0);
    rd_req = 1'b0; mem_read_ready = 1'b0; reset = 1'b1;
    step();
    chk("reset_clears_sticky", 0, 32'(timeout_error), 32'd0);
    chk("reset_rdata", 0, 32'(rd_data), 32'd0);
    reset = 1'b0;
    step();
    mon_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
